// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one uarttx among NUM_REQ byte producers.
// Define UART_TX_ARB_TIMEOUT_EN to enable the WAIT_DONE timeout and err pulse.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NEWD_HOLD = 128,
    parameter int TIMEOUT   = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         done,
    output logic                       newd,
    output logic [7:0]                 datatx,
    input  logic                       donetx,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = $clog2(NEWD_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_REL
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_owner;
    logic [IW-1:0]      w_idx;
    logic [7:0]         r_datatx;
    logic [7:0]         w_byte;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] w_ack_nxt;
    logic [NUM_REQ-1:0] w_done_nxt;
    logic [HW-1:0]      r_hold;
    logic               r_newd;
    logic               r_donetx_q;
    logic               w_found;
    logic               w_grant;
    logic               w_rise;
    logic               w_hold_end;
    logic               w_tmo_end;
    int                 w_dist;
    int                 w_best;

    assign w_rise     = donetx & ~r_donetx_q;
    assign w_hold_end = (r_hold == HW'(NEWD_HOLD - 1));

    // Smallest distance from ptr+1 (with wrap) wins, so the last winner is lowest priority.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_byte  = '0;
        w_dist  = 0;
        w_best  = NUM_REQ;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_dist = (k + NUM_REQ - 1 - int'(r_ptr)) % NUM_REQ;
            if (req[k] && (w_dist < w_best)) begin
                w_found = 1'b1;
                w_best  = w_dist;
                w_idx   = IW'(k);
                w_byte  = req_data[8*k +: 8];
            end
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_tmo;
    logic          r_err;
    logic          w_err_nxt;

    assign w_tmo_end = (r_tmo == TW'(TIMEOUT - 1));
    assign w_err_nxt = (r_state == S_WAIT) & ~w_rise & w_tmo_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
            if (r_state == S_WAIT)
                r_tmo <= r_tmo + 1'b1;
            else
                r_tmo <= '0;
        end
    end

    assign err = r_err;
`else
    assign w_tmo_end = (TIMEOUT < 0);
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_hold_end) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_rise || w_tmo_end) w_state_nxt = S_REL;
            S_REL:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_grant    = 1'b0;
        w_ack_nxt  = '0;
        w_done_nxt = '0;
        case (r_state)
            S_IDLE: begin
                w_grant = w_found;
                if (w_found) w_ack_nxt[w_idx] = 1'b1;
            end
            S_WAIT:  if (w_rise) w_done_nxt[r_owner] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= IW'(NUM_REQ - 1);
            r_owner    <= '0;
            r_datatx   <= '0;
            r_ack      <= '0;
            r_done     <= '0;
            r_newd     <= 1'b0;
            r_hold     <= '0;
            r_donetx_q <= 1'b0;
        end else begin
            r_donetx_q <= donetx;
            r_ack      <= w_ack_nxt;
            r_done     <= w_done_nxt;
            if (w_grant) begin
                r_ptr    <= w_idx;
                r_owner  <= w_idx;
                r_datatx <= w_byte;
                r_newd   <= 1'b1;
                r_hold   <= '0;
            end else if (r_state == S_ISSUE) begin
                if (w_hold_end)
                    r_newd <= 1'b0;
                else
                    r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign ack    = r_ack;
    assign done   = r_done;
    assign newd   = r_newd;
    assign datatx = r_datatx;
    assign owner  = r_owner;
    assign busy   = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a uarttx donetx model and grant scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int NH = 4;
    localparam int TO = 64;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic        newd;
    logic [7:0]  datatx;
    logic        donetx = 1'b0;
    logic        busy;
    logic [1:0]  owner;
    logic        err;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_done_cyc = -100;
    exp_t sb[$];

    bit   model_en = 1'b1;
    int   dcnt = 0;
    int   dhi = 0;
    logic newd_prev = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ(NR),
        .NEWD_HOLD(NH),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .done(done),
        .newd(newd),
        .datatx(datatx),
        .donetx(donetx),
        .busy(busy),
        .owner(owner),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Transmitter model: donetx rises 20 cycles after newd falls, held high 3 cycles.
    always @(posedge clk) begin
        #2;
        if (newd_prev && !newd && model_en) begin
            dcnt = 20;
        end else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
                donetx = 1'b1;
                dhi = 3;
            end
        end else if (dhi > 0) begin
            dhi--;
            if (dhi == 0) donetx = 1'b0;
        end
        newd_prev = newd;
    end

    task automatic sb_push(input int idx, input logic [7:0] d);
        exp_t e;
        e.idx  = 2'(idx);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        dcnt = 0;
        dhi = 0;
        donetx = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done !== 4'b0) last_done_cyc = cyc;
            if (ack !== 4'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ack, done, newd, datatx, busy, owner, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b done=%b newd=%b datatx=%h busy=%b owner=%0d err=%b, required all zero",
                     ack, done, newd, datatx, busy, owner, err);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || ack !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b ack=%b, required 0 / 0000", busy, ack);
        end
    endtask

    task automatic test_single();
        bit   ok;
        exp_t e;
        int   hi;
        int   n;
        do_reset();
        @(negedge clk);
        req_data[7:0] = 8'hA5;
        req = 4'b0001;
        sb_push(0, 8'hA5);
        wait_ack(ok);
        req = '0;
        e = sb.pop_front();
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_ack: no ack within bound");
        end else if (ack !== (4'b1 << e.idx) || datatx !== e.data || owner !== e.idx ||
                     newd !== 1'b1 || busy !== 1'b1 || done !== 4'b0) begin
            n_fail++;
            $display("FAIL single_grant: ack=%b datatx=%h owner=%0d newd=%b busy=%b, required ack=%b datatx=%h owner=%0d newd=1 busy=1",
                     ack, datatx, owner, newd, busy, 4'b1 << e.idx, e.data, e.idx);
        end
        hi = 0;
        while (newd === 1'b1 && hi < 20) begin
            hi++;
            @(negedge clk);
        end
        n_checks++;
        if (hi != NH) begin
            n_fail++;
            $display("FAIL single_newd_width: newd high %0d cycles, required %0d", hi, NH);
        end
        n = 0;
        while (donetx !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
            if (done !== 4'b0) last_done_cyc = cyc;
        end
        n_checks++;
        if (donetx !== 1'b1 || done !== 4'b0) begin
            n_fail++;
            $display("FAIL single_pre_done: donetx=%b done=%b, required 1 / 0000", donetx, done);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 4'b0001 || ack !== 4'b0) begin
            n_fail++;
            $display("FAIL single_done: done=%b ack=%b, required 0001 / 0000", done, ack);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 4'b0) begin
            n_fail++;
            $display("FAIL single_release: busy=%b done=%b, required 0 / 0000", busy, done);
        end
    endtask

    task automatic test_round_robin();
        bit   ok;
        exp_t e;
        do_reset();
        @(negedge clk);
        req_data = 32'h13121110;
        req = 4'b1111;
        sb_push(0, 8'h10);
        sb_push(1, 8'h11);
        sb_push(2, 8'h12);
        sb_push(3, 8'h13);
        sb_push(0, 8'h10);
        for (int g = 0; g < 5; g++) begin
            wait_ack(ok);
            e = sb.pop_front();
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rr_ack%0d: no ack within bound", g);
            end else if (ack !== (4'b1 << e.idx) || datatx !== e.data ||
                         owner !== e.idx || done !== 4'b0) begin
                n_fail++;
                $display("FAIL rr_grant%0d: ack=%b datatx=%h owner=%0d done=%b, required ack=%b datatx=%h owner=%0d done=0000",
                         g, ack, datatx, owner, done, 4'b1 << e.idx, e.data, e.idx);
            end
            if (g > 0) begin
                n_checks++;
                if (cyc - last_done_cyc < 2) begin
                    n_fail++;
                    $display("FAIL rr_gap%0d: done-to-ack gap %0d, required >= 2", g, cyc - last_done_cyc);
                end
            end
        end
        req = '0;
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rr_idle: busy still %b after bound, required 0", busy);
        end
    endtask

    task automatic test_priority();
        bit   ok;
        exp_t e;
        do_reset();
        @(negedge clk);
        req_data = 32'h00220000;
        req = 4'b0100;
        sb_push(2, 8'h22);
        wait_ack(ok);
        req_data = 32'h00320030;
        req = 4'b0101;
        e = sb.pop_front();
        n_checks++;
        if (!ok || ack !== (4'b1 << e.idx) || datatx !== e.data) begin
            n_fail++;
            $display("FAIL prio_first: ack=%b datatx=%h, required ack=%b datatx=%h",
                     ack, datatx, 4'b1 << e.idx, e.data);
        end
        sb_push(0, 8'h30);
        wait_ack(ok);
        req = '0;
        e = sb.pop_front();
        n_checks++;
        if (!ok || ack !== (4'b1 << e.idx) || datatx !== e.data || owner !== e.idx) begin
            n_fail++;
            $display("FAIL prio_next: ack=%b datatx=%h owner=%0d, required ack=%b datatx=%h owner=%0d",
                     ack, datatx, owner, 4'b1 << e.idx, e.data, e.idx);
        end
        wait_idle(ok);
    endtask

    task automatic test_reset_mid();
        bit   ok;
        bit   bad_done;
        bit   bad_busy;
        exp_t e;
        int   n;
        do_reset();
        @(negedge clk);
        req_data = 32'h00007700;
        req = 4'b0010;
        sb_push(1, 8'h77);
        wait_ack(ok);
        req = '0;
        e = sb.pop_front();
        n_checks++;
        if (!ok || ack !== (4'b1 << e.idx) || datatx !== e.data) begin
            n_fail++;
            $display("FAIL rmid_grant: ack=%b datatx=%h, required ack=%b datatx=%h",
                     ack, datatx, 4'b1 << e.idx, e.data);
        end
        n = 0;
        while (newd === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ack, done, newd, datatx, busy, owner, err} !== '0) begin
            n_fail++;
            $display("FAIL rmid_reset: ack=%b done=%b newd=%b datatx=%h busy=%b owner=%0d err=%b, required all zero",
                     ack, done, newd, datatx, busy, owner, err);
        end
        rst = 1'b0;
        bad_done = 1'b0;
        bad_busy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 4'b0) bad_done = 1'b1;
            if (busy !== 1'b0) bad_busy = 1'b1;
        end
        n_checks++;
        if (bad_done || bad_busy) begin
            n_fail++;
            $display("FAIL rmid_abandon: done_seen=%b busy_seen=%b, required 0 / 0", bad_done, bad_busy);
        end
        req_data = 32'h43424140;
        req = 4'b1111;
        sb_push(0, 8'h40);
        wait_ack(ok);
        req = '0;
        e = sb.pop_front();
        n_checks++;
        if (!ok || ack !== (4'b1 << e.idx) || datatx !== e.data || owner !== e.idx) begin
            n_fail++;
            $display("FAIL rmid_first_grant: ack=%b datatx=%h owner=%0d, required ack=%b datatx=%h owner=%0d",
                     ack, datatx, owner, 4'b1 << e.idx, e.data, e.idx);
        end
        wait_idle(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rmid_idle: busy=%b after bound, required 0", busy);
        end
    endtask

    task automatic test_timeout();
        bit   ok;
        bit   bad_done;
        exp_t e;
        int   n;
        int   n0;
        do_reset();
        model_en = 1'b0;
        @(negedge clk);
        req_data = 32'h0000005A;
        req = 4'b0001;
        sb_push(0, 8'h5A);
        wait_ack(ok);
        req = '0;
        e = sb.pop_front();
        n_checks++;
        if (!ok || ack !== (4'b1 << e.idx) || datatx !== e.data) begin
            n_fail++;
            $display("FAIL tmo_grant: ack=%b datatx=%h, required ack=%b datatx=%h",
                     ack, datatx, 4'b1 << e.idx, e.data);
        end
        n = 0;
        while (newd === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n0 = cyc;
        bad_done = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        begin
            int err_at;
            err_at = -1;
            for (int i = 0; i < 100; i++) begin
                if (done !== 4'b0) bad_done = 1'b1;
                if (err === 1'b1) begin
                    err_at = cyc;
                    break;
                end
                @(negedge clk);
            end
            n_checks++;
            if (err_at != n0 + TO) begin
                n_fail++;
                $display("FAIL tmo_err_time: err at %0d cycles into WAIT_DONE, required %0d",
                         (err_at < 0) ? -1 : err_at - n0, TO);
            end
            @(negedge clk);
            if (done !== 4'b0) bad_done = 1'b1;
            n_checks++;
            if (err !== 1'b0 || busy !== 1'b0 || bad_done) begin
                n_fail++;
                $display("FAIL tmo_release: err=%b busy=%b done_seen=%b, required 0 / 0 / 0",
                         err, busy, bad_done);
            end
        end
`else
        begin
            bit bad_busy;
            bit bad_err;
            bad_busy = 1'b0;
            bad_err = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (busy !== 1'b1) bad_busy = 1'b1;
                if (err !== 1'b0) bad_err = 1'b1;
                if (done !== 4'b0) bad_done = 1'b1;
            end
            n_checks++;
            if (bad_busy || bad_err || bad_done) begin
                n_fail++;
                $display("FAIL tmo_disabled: busy_dropped=%b err_seen=%b done_seen=%b, required 0 / 0 / 0",
                         bad_busy, bad_err, bad_done);
            end
        end
`endif
        model_en = 1'b1;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_priority();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uarttx` transmitter among `NUM_REQ` byte producers. It accepts one byte at a time from the winning requester and drives the transmitter's `newd`/`datatx`. It holds `newd` long enough to be sampled by the transmitter's slow bit clock, then waits for `donetx` before granting again. It sits between client logic and the `uarttx` instance, in the `clk` domain.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `NEWD_HOLD`, 128, `clk` cycles `newd` is held high; must be at least one transmitter bit-clock period
- `TIMEOUT`, 4096, `clk` cycles allowed in WAIT_DONE (used only with the configuration macro)

Ports:
- `clk` in 1 — system clock; the only clock
- `rst` in 1 — reset, synchronous, active-high
- `req` in NUM_REQ — per-requester byte-valid level
- `req_data` in 8*NUM_REQ — byte i at [8i+7:8i]
- `ack` out NUM_REQ — one-cycle pulse: requester's byte latched; requester may change data
- `done` out NUM_REQ — one-cycle pulse: requester's frame completed
- `newd` out 1 — to `uarttx.newd`
- `datatx` out 8 — to `uarttx.datatx`
- `donetx` in 1 — from `uarttx.donetx` (level, slow-clock based)
- `busy` out 1 — high in every state except IDLE
- `owner` out clog2(NUM_REQ) — index of current or last grantee
- `err` out 1 — timeout pulse; constant 0 without the macro

## Operation
- States: IDLE, ISSUE, WAIT_DONE, RELEASE.
- IDLE: if any `req` bit is set, select the first set bit, searching from `ptr+1` upward with wrap-around.
  - Latch its byte into `datatx`.
  - Set `owner` and `ptr` to it.
  - Pulse `ack[owner]`, set `newd`=1 and a hold counter to 0, then go to ISSUE.
  - With no `req` bits set, stay in IDLE.
- ISSUE: increment the hold counter each cycle. When it reaches NEWD_HOLD-1, clear `newd` and go to WAIT_DONE.
  - `donetx` edges in this state are ignored.
- WAIT_DONE: wait for a rising edge of `donetx`, detected as `donetx & ~donetx_q` with `donetx_q` registered every cycle.
  - On the edge: pulse `done[owner]` and go to RELEASE.
- RELEASE: one cycle; `req` is ignored; return to IDLE.
- `datatx` holds its value from grant until the next grant.
- Requester rules:
  - A requester keeps `req` and data stable until its `ack`.
  - Dropping `req` before `ack` withdraws the request.
  - `req` held after `ack` is treated as a new request on a later arbitration.
- Fairness: the winner becomes lowest priority. With all requesters active, grant order is 0,1,2,3,0,...

## Timing
- Reset values:
  - `newd`=0, `datatx`=0, `ack`=0, `done`=0, `busy`=0, `owner`=0, `err`=0
  - `ptr`=NUM_REQ-1, so requester 0 wins first
  - `donetx_q`=0, state=IDLE
- Grant latency: `req` sampled high at edge k in IDLE ⇒ `ack`, `newd`, `datatx`, `owner` and `busy` are valid after edge k.
- `newd` is high for exactly NEWD_HOLD cycles.
- `done` is asserted the cycle after the edge where the `donetx` rise is sampled.
- After `done`, the earliest next `ack` comes 2 cycles later (RELEASE, then IDLE sample).
- Simultaneous requests: exactly one `ack` bit is high in any cycle; `ack` and `done` are never high in the same cycle.
- Reset mid-operation: all outputs take reset values on the next edge and any in-flight frame is abandoned (no `done`). `donetx` activity after reset cannot complete anything, because IDLE ignores it.

## Configuration
- `UART_TX_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT_DONE.
  - If TIMEOUT cycles pass with no `donetx` rise, pulse `err` for one cycle, suppress `done[owner]`, and go to RELEASE.
  - The counter clears on entry to WAIT_DONE.
- Not defined: no counter; WAIT_DONE waits indefinitely; `err` is tied 0.

## Test plan
- Setup for all cases: NUM_REQ=4, NEWD_HOLD=4, TIMEOUT=64; the bench model raises `donetx` 20 cycles after `newd` falls.
- Single request: `req`=0001, byte 0xA5.
  - Expect `ack`=0001 in the same cycle as `newd`=1 and `datatx`=0xA5.
  - Expect `newd` high 4 cycles, `done`=0001 one cycle after the `donetx` rise, then `busy`=0.
- All requesters held: `req`=1111 with bytes 0x10/0x11/0x12/0x13.
  - Expect grants 0,1,2,3,0 with `datatx` following.
  - Expect exactly one `ack` bit per grant and a ≥2-cycle gap after each `done`.
- Winner lowest priority: grant requester 2 first, then assert `req`=0101.
  - Expect the next grant to requester 0 (search order 3,0,1,2).
- Reset mid-operation: assert `rst` during WAIT_DONE.
  - Expect all outputs at reset values next cycle and no `done` when `donetx` later rises.
  - Expect the first grant after reset to go to requester 0.
- Timeout, macro defined: bench never raises `donetx`.
  - Expect `err` pulse 64 cycles into WAIT_DONE, no `done`, then return to IDLE.
  - With the macro undefined, expect `busy` to stay 1 and `err` to stay 0.
